// File: rtl/varredura_display_pkg.sv
// Shared definitions for the display scanner: slot state encoding,
// nibble width and the default digit count.
package varredura_display_pkg;

    typedef enum logic {
        APAGADO = 1'b0,
        ATIVO   = 1'b1
    } estado_t;

    localparam int LARGURA_NIBBLE   = 4;
    localparam int N_DIGITOS_PADRAO = 4;

endpackage

// File: rtl/divisor_varredura.sv
// Slot counter for the display scanner: counts DIV_VARREDURA cycles per
// digit slot and steps the digit index, wrapping after N_DIGITOS slots.
// The next-cycle values are exported so the top can register its outputs
// in step with the counter. A synchronous clear holds everything at slot 0.
module divisor_varredura #(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000,
    localparam int CNT_W        = $clog2(DIV_VARREDURA),
    localparam int IDX_W        = $clog2(N_DIGITOS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             limpa,
    output logic [CNT_W-1:0] cnt_prox,
    output logic [IDX_W-1:0] idx_prox,
    output logic             volta
);

    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;

    // Next slot position; volta flags the edge where the index wraps to 0
    always_comb begin
        cnt_prox = cnt_r;
        idx_prox = idx_r;
        volta    = 1'b0;
        if (limpa) begin
            cnt_prox = {CNT_W{1'b0}};
            idx_prox = {IDX_W{1'b0}};
        end else if (cnt_r == CNT_W'(DIV_VARREDURA - 1)) begin
            cnt_prox = {CNT_W{1'b0}};
            if (idx_r == IDX_W'(N_DIGITOS - 1)) begin
                idx_prox = {IDX_W{1'b0}};
                volta    = 1'b1;
            end else begin
                idx_prox = idx_r + IDX_W'(1);
            end
        end else begin
            cnt_prox = cnt_r + CNT_W'(1);
        end
    end

    // Counter and index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            cnt_r <= cnt_prox;
            idx_r <= idx_prox;
        end
    end

endmodule

// File: rtl/varredura_display.sv
// Time-multiplexed display scanner. Feeds one nibble at a time to the
// seven-segment decoder with a one-hot digit enable, blanking the start of
// every slot, optionally suppressing leading zeros and blinking digits.
// All outputs are registered from the next-cycle scan position so that the
// enable, the nibble and the frame pulse line up with the slot counter.
module varredura_display
    import varredura_display_pkg::*;
#(
    parameter int N_DIGITOS     = N_DIGITOS_PADRAO,
    parameter int DIV_VARREDURA = 50000,
    parameter int TEMPO_APAGADO = 64,
    parameter int PISCA_QUADROS = 64
) (
    input  logic                                Clock,
    input  logic                                Reset,
    input  logic                                Habilita,
    input  logic [LARGURA_NIBBLE*N_DIGITOS-1:0] Digitos,
    input  logic                                Supressao_Zeros,
    input  logic [N_DIGITOS-1:0]                Pisca_Mascara,
    output logic [LARGURA_NIBBLE-1:0]           Num_Binario,
    output logic [N_DIGITOS-1:0]                Digito_Ativo,
    output logic                                Fim_Quadro
);

    localparam int CNT_W    = $clog2(DIV_VARREDURA);
    localparam int IDX_W    = $clog2(N_DIGITOS);
    localparam int DIG_W    = LARGURA_NIBBLE * N_DIGITOS;
    localparam int QUADRO_W = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;

    logic                      en_prev_r;
    logic [DIG_W-1:0]          shadow_r;
    logic                      fase_r;
    logic [QUADRO_W-1:0]       quadros_r;
    estado_t                   estado_r;

    logic                      limpa_s;
    logic [CNT_W-1:0]          cnt_prox_s;
    logic [IDX_W-1:0]          idx_prox_s;
    logic                      volta_s;
    logic [DIG_W-1:0]          shadow_prox_s;
    logic                      fase_prox_s;
    logic [QUADRO_W-1:0]       quadros_prox_s;
    estado_t                   estado_prox_s;
    logic                      apaga_s;
    logic [LARGURA_NIBBLE-1:0] num_prox_s;
    logic [N_DIGITOS-1:0]      ativo_prox_s;

    // True when digit k and every digit to its left are zero (digit 0 never)
    function automatic logic zeros_a_esquerda(input logic [DIG_W-1:0] d,
                                              input logic [IDX_W-1:0] k);
        logic todos_zero;
        todos_zero = (k != {IDX_W{1'b0}});
        for (int j = 0; j < N_DIGITOS; j++) begin
            if ((j >= int'(k)) &&
                (d[j*LARGURA_NIBBLE +: LARGURA_NIBBLE] != {LARGURA_NIBBLE{1'b0}})) begin
                todos_zero = 1'b0;
            end else begin
                todos_zero = todos_zero;
            end
        end
        return todos_zero;
    endfunction

    // The first enabled edge after reset or re-enable restarts slot 0
    assign limpa_s = !Habilita || !en_prev_r;

    divisor_varredura #(
        .N_DIGITOS     (N_DIGITOS),
        .DIV_VARREDURA (DIV_VARREDURA)
    ) u_divisor (
        .clk      (Clock),
        .rst      (Reset),
        .limpa    (limpa_s),
        .cnt_prox (cnt_prox_s),
        .idx_prox (idx_prox_s),
        .volta    (volta_s)
    );

    // Slot state transitions: dark until the blank interval ends, lit to slot end
    always_comb begin
        estado_prox_s = estado_r;
        if (!Habilita) begin
            estado_prox_s = APAGADO;
        end else if (cnt_prox_s == CNT_W'(TEMPO_APAGADO)) begin
            estado_prox_s = ATIVO;
        end else if (cnt_prox_s == {CNT_W{1'b0}}) begin
            estado_prox_s = APAGADO;
        end else begin
            estado_prox_s = estado_r;
        end
    end

    // Frame-synchronous shadow, blink timing and next output values
    always_comb begin
        shadow_prox_s  = shadow_r;
        fase_prox_s    = fase_r;
        quadros_prox_s = quadros_r;
        ativo_prox_s   = {N_DIGITOS{1'b0}};
        num_prox_s     = Num_Binario;

        if (volta_s || (Habilita && !en_prev_r)) begin
            shadow_prox_s = Digitos;
        end else begin
            shadow_prox_s = shadow_r;
        end

        if (volta_s) begin
            if (quadros_r == QUADRO_W'(PISCA_QUADROS - 1)) begin
                quadros_prox_s = {QUADRO_W{1'b0}};
                fase_prox_s    = !fase_r;
            end else begin
                quadros_prox_s = quadros_r + QUADRO_W'(1);
            end
        end else begin
            quadros_prox_s = quadros_r;
        end

        apaga_s = (Pisca_Mascara[idx_prox_s] && fase_prox_s) ||
                  (Supressao_Zeros && zeros_a_esquerda(shadow_prox_s, idx_prox_s));

        if (Habilita) begin
            num_prox_s = shadow_prox_s[idx_prox_s*LARGURA_NIBBLE +: LARGURA_NIBBLE];
        end else begin
            num_prox_s = Num_Binario;
        end

        if ((estado_prox_s == ATIVO) && !apaga_s) begin
            ativo_prox_s = {{(N_DIGITOS-1){1'b0}}, 1'b1} << idx_prox_s;
        end else begin
            ativo_prox_s = {N_DIGITOS{1'b0}};
        end
    end

    // Slot state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_r <= APAGADO;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // Shadow, blink phase, frame count and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            en_prev_r    <= 1'b0;
            shadow_r     <= {DIG_W{1'b0}};
            fase_r       <= 1'b0;
            quadros_r    <= {QUADRO_W{1'b0}};
            Num_Binario  <= {LARGURA_NIBBLE{1'b0}};
            Digito_Ativo <= {N_DIGITOS{1'b0}};
            Fim_Quadro   <= 1'b0;
        end else begin
            en_prev_r    <= Habilita;
            shadow_r     <= shadow_prox_s;
            fase_r       <= fase_prox_s;
            quadros_r    <= quadros_prox_s;
            Num_Binario  <= num_prox_s;
            Digito_Ativo <= ativo_prox_s;
            Fim_Quadro   <= volta_s;
        end
    end

endmodule

// File: tb/tb_varredura_display.sv
// Bench for varredura_display: a cycle model pushes the expected outputs of
// each edge into a queue; after the edge they are popped and compared, and
// per-digit lit-cycle totals are checked against hand-computed values.
module tb_varredura_display;

    localparam int N      = 4;
    localparam int DIV    = 8;
    localparam int TEMPO  = 2;
    localparam int PISCA  = 2;
    localparam int QUADRO = N * DIV;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Habilita;
    logic [15:0] Digitos;
    logic        Supressao_Zeros;
    logic [3:0]  Pisca_Mascara;
    logic [3:0]  Num_Binario;
    logic [3:0]  Digito_Ativo;
    logic        Fim_Quadro;

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] ativo;
        logic       fim;
    } saida_t;

    saida_t      fila[$];
    int          n_checks = 0;
    int          n_errors = 0;

    int          m_run, m_pos, m_fase, m_quadros;
    logic [15:0] m_shadow;
    logic [3:0]  m_num;
    int          acesos[4];
    int          n_fim;
    int          ciclo_n;
    int          ultimo_fim;

    varredura_display #(
        .N_DIGITOS     (N),
        .DIV_VARREDURA (DIV),
        .TEMPO_APAGADO (TEMPO),
        .PISCA_QUADROS (PISCA)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Habilita        (Habilita),
        .Digitos         (Digitos),
        .Supressao_Zeros (Supressao_Zeros),
        .Pisca_Mascara   (Pisca_Mascara),
        .Num_Binario     (Num_Binario),
        .Digito_Ativo    (Digito_Ativo),
        .Fim_Quadro      (Fim_Quadro)
    );

    always #5 Clock = ~Clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Expected outputs after the coming edge, from the current inputs
    task automatic modelo();
        saida_t e;
        int     slot;
        int     desl;
        logic   apaga;
        e.fim   = 1'b0;
        e.ativo = 4'b0000;
        if (Reset) begin
            m_run = 0; m_pos = 0; m_shadow = 16'h0; m_fase = 0; m_quadros = 0; m_num = 4'h0;
        end else if (!Habilita) begin
            m_run = 0; m_pos = 0;
        end else begin
            if (m_run == 0) begin
                m_run = 1; m_pos = 0; m_shadow = Digitos;
            end else if (m_pos == QUADRO - 1) begin
                m_pos = 0; m_shadow = Digitos; e.fim = 1'b1; m_quadros++;
                if (m_quadros == PISCA) begin
                    m_quadros = 0; m_fase = 1 - m_fase;
                end
            end else begin
                m_pos++;
            end
            slot  = m_pos / DIV;
            desl  = m_pos % DIV;
            m_num = m_shadow[slot*4 +: 4];
            apaga = (Pisca_Mascara[slot] && m_fase == 1) ||
                    (Supressao_Zeros && slot > 0 && (m_shadow >> (slot*4)) == 16'h0);
            if (desl >= TEMPO && !apaga) e.ativo = 4'b0001 << slot;
        end
        e.num = m_num;
        fila.push_back(e);
    endtask

    task automatic ciclo(input int n);
        saida_t e;
        for (int i = 0; i < n; i++) begin
            if (Reset || !Habilita) ultimo_fim = -1;
            modelo();
            @(posedge Clock);
            #1;
            ciclo_n++;
            e = fila.pop_front();
            verifica("num", Num_Binario, e.num);
            verifica("ativo", Digito_Ativo, e.ativo);
            verifica("fim", Fim_Quadro, e.fim);
            verifica("um_quente", $countones(Digito_Ativo) <= 1, 1);
            for (int k = 0; k < 4; k++) if (Digito_Ativo[k]) acesos[k]++;
            if (Fim_Quadro) begin
                n_fim++;
                if (ultimo_fim >= 0) verifica("periodo_fim", ciclo_n - ultimo_fim, QUADRO);
                ultimo_fim = ciclo_n;
            end
        end
    endtask

    task automatic zera();
        for (int k = 0; k < 4; k++) acesos[k] = 0;
        n_fim = 0;
    endtask

    task automatic confere_acesos(input string tag, input int a3, input int a2, input int a1, input int a0);
        verifica({tag, "_d3"}, acesos[3], a3);
        verifica({tag, "_d2"}, acesos[2], a2);
        verifica({tag, "_d1"}, acesos[1], a1);
        verifica({tag, "_d0"}, acesos[0], a0);
    endtask

    initial begin
        Reset = 1'b1; Habilita = 1'b0; Digitos = 16'h0000;
        Supressao_Zeros = 1'b0; Pisca_Mascara = 4'b0000;
        ultimo_fim = -1; ciclo_n = 0;
        zera();

        // reset state
        ciclo(3);
        verifica("reset_num", Num_Binario, 4'h0);
        verifica("reset_ativo", Digito_Ativo, 4'h0);
        verifica("reset_fim", Fim_Quadro, 1'b0);

        // basic scan of 1234
        Reset = 1'b0; Habilita = 1'b1; Digitos = 16'h1234;
        zera();
        ciclo(65);
        confere_acesos("scan", 12, 12, 12, 12);
        verifica("scan_nfim", n_fim, 2);

        // mid-frame change during slot 1 shows up next frame
        ciclo(10);
        Digitos = 16'h5678;
        ciclo(1);
        verifica("sem_rasgo", Num_Binario, 4'h3);
        ciclo(21);
        verifica("novo_quadro", Num_Binario, 4'h8);
        ciclo(31);

        // leading-zero suppression
        Supressao_Zeros = 1'b1; Digitos = 16'h0040;
        ciclo(32);
        zera();
        ciclo(32);
        confere_acesos("zeros_0040", 0, 0, 6, 6);
        Digitos = 16'h0000;
        ciclo(32);
        zera();
        ciclo(32);
        confere_acesos("zeros_0000", 0, 0, 0, 6);

        // blink, starting from reset so the phase is known
        Supressao_Zeros = 1'b0; Digitos = 16'h1234; Pisca_Mascara = 4'b1100;
        Reset = 1'b1;
        ciclo(2);
        Reset = 1'b0;
        zera();
        ciclo(64);
        confere_acesos("pisca_q01", 12, 12, 12, 12);
        zera();
        ciclo(64);
        confere_acesos("pisca_q23", 0, 0, 12, 12);
        zera();
        ciclo(64);
        confere_acesos("pisca_q45", 12, 12, 12, 12);

        // drop and re-raise Habilita mid slot 2
        Pisca_Mascara = 4'b0000;
        ciclo(20);
        verifica("ativo_slot2", Digito_Ativo, 4'b0100);
        Habilita = 1'b0;
        ciclo(1);
        verifica("desliga", Digito_Ativo, 4'b0000);
        ciclo(3);
        Digitos = 16'hABC9; Habilita = 1'b1;
        ciclo(1);
        verifica("reinicio_escuro1", Digito_Ativo, 4'b0000);
        verifica("reinicio_num", Num_Binario, 4'h9);
        ciclo(1);
        verifica("reinicio_escuro2", Digito_Ativo, 4'b0000);
        ciclo(1);
        verifica("reinicio_aceso", Digito_Ativo, 4'b0001);
        verifica("reinicio_num2", Num_Binario, 4'h9);
        ciclo(61);

        // asynchronous reset during the lit part of slot 3
        ciclo(27);
        verifica("ativo_slot3", Digito_Ativo, 4'b1000);
        Reset = 1'b1;
        #1;
        verifica("async_num", Num_Binario, 4'h0);
        verifica("async_ativo", Digito_Ativo, 4'h0);
        verifica("async_fim", Fim_Quadro, 1'b0);
        ciclo(2);
        Reset = 1'b0;
        ciclo(1);
        verifica("pos_reset_num", Num_Binario, 4'h9);
        verifica("pos_reset_ativo", Digito_Ativo, 4'b0000);
        ciclo(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
